// File: rtl/mac_stream_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mac_stream_driver                                                          |
// | Streams one convolution window into a MAC and returns its result on a      |
// | valid/ready port. Optional ReLU on the result: define MAC_DRV_RELU_EN.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mac_stream_driver #(
  parameter int INPUT_BIT_RESOLUTION  = 8,
  parameter int OUTPUT_BIT_RESOLUTION = 32,
  parameter int KERNEL_LEN            = 9,
  parameter int ADDR_WIDTH            = 4,
  parameter int TIMEOUT_CYCLES        = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             cfg_wr_en_i,
  input  logic [ADDR_WIDTH-1:0]            cfg_wr_addr_i,
  input  logic [INPUT_BIT_RESOLUTION-1:0]  cfg_fin_i,
  input  logic [INPUT_BIT_RESOLUTION-1:0]  cfg_kernel_i,
  input  logic                             cfg_bias_wr_en_i,
  input  logic [OUTPUT_BIT_RESOLUTION-1:0] cfg_bias_i,
  input  logic                             start_i,
  output logic                             busy_o,
  output logic                             mac_fin_and_kernel_valid_o,
  output logic [INPUT_BIT_RESOLUTION-1:0]  mac_fin_data_o,
  output logic [INPUT_BIT_RESOLUTION-1:0]  mac_kernel_data_o,
  output logic [OUTPUT_BIT_RESOLUTION-1:0] mac_kernel_bias_o,
  input  logic                             mac_valid_i,
  input  logic [OUTPUT_BIT_RESOLUTION-1:0] mac_data_i,
  output logic                             mac_ready_o,
  output logic                             res_valid_o,
  output logic [OUTPUT_BIT_RESOLUTION-1:0] res_data_o,
  input  logic                             res_ready_i,
  output logic                             timeout_o
);

  localparam int                    c_DEPTH    = 2 ** ADDR_WIDTH;
  localparam int                    c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH:0]   c_KLEN     = (ADDR_WIDTH + 1)'(KERNEL_LEN);
  localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX = ADDR_WIDTH'(KERNEL_LEN - 1);
  localparam logic [c_TMO_W-1:0]    c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_STREAM   = 3'd2,
    S_WAIT_RES = 3'd3,
    S_OUT_RES  = 3'd4
  } state_t;

  state_t                           r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]            r_idx, w_idx_nxt, w_idx_inc;
  logic [c_TMO_W-1:0]               r_tmo, w_tmo_nxt;
  logic [INPUT_BIT_RESOLUTION-1:0]  r_fin  [0:c_DEPTH-1];
  logic [INPUT_BIT_RESOLUTION-1:0]  r_kern [0:c_DEPTH-1];
  logic [OUTPUT_BIT_RESOLUTION-1:0] r_bias;

  logic                             r_busy, w_busy_nxt;
  logic                             r_valid, w_valid_nxt;
  logic [INPUT_BIT_RESOLUTION-1:0]  r_fin_data, w_fin_data_nxt;
  logic [INPUT_BIT_RESOLUTION-1:0]  r_kern_data, w_kern_data_nxt;
  logic [OUTPUT_BIT_RESOLUTION-1:0] r_bias_out, w_bias_out_nxt;
  logic                             r_ready, w_ready_nxt;
  logic                             r_res_valid, w_res_valid_nxt;
  logic [OUTPUT_BIT_RESOLUTION-1:0] r_res_data, w_res_data_nxt;
  logic                             r_timeout, w_timeout_nxt;

  logic                             w_entry_wr, w_bias_wr;
  logic [OUTPUT_BIT_RESOLUTION-1:0] w_bias_eff, w_res_in;

  assign w_entry_wr = (r_state == S_IDLE) && cfg_wr_en_i && ({1'b0, cfg_wr_addr_i} < c_KLEN);
  assign w_bias_wr  = (r_state == S_IDLE) && cfg_bias_wr_en_i;
  // A bias write coinciding with start must already reach the MAC this run.
  assign w_bias_eff = w_bias_wr ? cfg_bias_i : r_bias;
  assign w_idx_inc  = r_idx + ADDR_WIDTH'(1);

  always_comb begin
`ifdef MAC_DRV_RELU_EN
    w_res_in = mac_data_i[OUTPUT_BIT_RESOLUTION-1] ? '0 : mac_data_i;
`else
    w_res_in = mac_data_i;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_fin[i]  <= '0;
        r_kern[i] <= '0;
      end
      r_bias <= '0;
    end else begin
      if (w_entry_wr) begin
        r_fin[cfg_wr_addr_i]  <= cfg_fin_i;
        r_kern[cfg_wr_addr_i] <= cfg_kernel_i;
      end
      if (w_bias_wr) begin
        r_bias <= cfg_bias_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_fin_data  <= '0;
      r_kern_data <= '0;
      r_bias_out  <= '0;
      r_ready     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_tmo       <= w_tmo_nxt;
      r_busy      <= w_busy_nxt;
      r_valid     <= w_valid_nxt;
      r_fin_data  <= w_fin_data_nxt;
      r_kern_data <= w_kern_data_nxt;
      r_bias_out  <= w_bias_out_nxt;
      r_ready     <= w_ready_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_res_data  <= w_res_data_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  // Next-state and next-output decode; every output is the registered copy.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_tmo_nxt       = r_tmo;
    w_busy_nxt      = r_busy;
    w_valid_nxt     = 1'b0;
    w_fin_data_nxt  = '0;
    w_kern_data_nxt = '0;
    w_bias_out_nxt  = r_bias_out;
    w_ready_nxt     = 1'b0;
    w_res_valid_nxt = 1'b0;
    w_res_data_nxt  = '0;
    w_timeout_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_busy_nxt     = 1'b0;
        w_bias_out_nxt = '0;
        if (start_i) begin
          // Zero-product lead cycle: the MAC treats its first valid as entry.
          w_state_nxt    = S_PREAMBLE;
          w_busy_nxt     = 1'b1;
          w_valid_nxt    = 1'b1;
          w_bias_out_nxt = w_bias_eff;
        end
      end
      S_PREAMBLE: begin
        w_state_nxt     = S_STREAM;
        w_idx_nxt       = '0;
        w_valid_nxt     = 1'b1;
        w_fin_data_nxt  = r_fin[0];
        w_kern_data_nxt = r_kern[0];
      end
      S_STREAM: begin
        if (r_idx == c_LAST_IDX) begin
          w_state_nxt = S_WAIT_RES;
          w_tmo_nxt   = '0;
          w_ready_nxt = 1'b1;
        end else begin
          w_idx_nxt       = w_idx_inc;
          w_valid_nxt     = 1'b1;
          w_fin_data_nxt  = r_fin[w_idx_inc];
          w_kern_data_nxt = r_kern[w_idx_inc];
        end
      end
      S_WAIT_RES: begin
        if (mac_valid_i) begin
          w_state_nxt     = S_OUT_RES;
          w_res_valid_nxt = 1'b1;
          w_res_data_nxt  = w_res_in;
          w_bias_out_nxt  = '0;
        end else if (r_tmo == c_TMO_LAST) begin
          w_state_nxt    = S_IDLE;
          w_timeout_nxt  = 1'b1;
          w_busy_nxt     = 1'b0;
          w_bias_out_nxt = '0;
        end else begin
          w_tmo_nxt   = r_tmo + c_TMO_W'(1);
          w_ready_nxt = 1'b1;
        end
      end
      S_OUT_RES: begin
        if (res_ready_i) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_res_valid_nxt = 1'b1;
          w_res_data_nxt  = r_res_data;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign busy_o                     = r_busy;
  assign mac_fin_and_kernel_valid_o = r_valid;
  assign mac_fin_data_o             = r_fin_data;
  assign mac_kernel_data_o          = r_kern_data;
  assign mac_kernel_bias_o          = r_bias_out;
  assign mac_ready_o                = r_ready;
  assign res_valid_o                = r_res_valid;
  assign res_data_o                 = r_res_data;
  assign timeout_o                  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mac_stream_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mac_stream_driver                                                       |
// | Randomized self-checking bench with a window-sum model and a MAC stub.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mac_stream_driver;

  localparam int IW  = 8;
  localparam int OW  = 32;
  localparam int K   = 9;
  localparam int AW  = 4;
  localparam int TMO = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cfg_wr_en_i = 1'b0;
  logic [AW-1:0] cfg_wr_addr_i = '0;
  logic [IW-1:0] cfg_fin_i = '0;
  logic [IW-1:0] cfg_kernel_i = '0;
  logic          cfg_bias_wr_en_i = 1'b0;
  logic [OW-1:0] cfg_bias_i = '0;
  logic          start_i = 1'b0;
  logic          mac_valid_i = 1'b0;
  logic [OW-1:0] mac_data_i = '0;
  logic          res_ready_i = 1'b0;

  logic          busy_o;
  logic          mac_fin_and_kernel_valid_o;
  logic [IW-1:0] mac_fin_data_o;
  logic [IW-1:0] mac_kernel_data_o;
  logic [OW-1:0] mac_kernel_bias_o;
  logic          mac_ready_o;
  logic          res_valid_o;
  logic [OW-1:0] res_data_o;
  logic          timeout_o;

  mac_stream_driver #(
    .INPUT_BIT_RESOLUTION (IW),
    .OUTPUT_BIT_RESOLUTION(OW),
    .KERNEL_LEN           (K),
    .ADDR_WIDTH           (AW),
    .TIMEOUT_CYCLES       (TMO)
  ) u_dut (
    .clk_i                     (clk_i),
    .rst_ni                    (rst_ni),
    .cfg_wr_en_i               (cfg_wr_en_i),
    .cfg_wr_addr_i             (cfg_wr_addr_i),
    .cfg_fin_i                 (cfg_fin_i),
    .cfg_kernel_i              (cfg_kernel_i),
    .cfg_bias_wr_en_i          (cfg_bias_wr_en_i),
    .cfg_bias_i                (cfg_bias_i),
    .start_i                   (start_i),
    .busy_o                    (busy_o),
    .mac_fin_and_kernel_valid_o(mac_fin_and_kernel_valid_o),
    .mac_fin_data_o            (mac_fin_data_o),
    .mac_kernel_data_o         (mac_kernel_data_o),
    .mac_kernel_bias_o         (mac_kernel_bias_o),
    .mac_valid_i               (mac_valid_i),
    .mac_data_i                (mac_data_i),
    .mac_ready_o               (mac_ready_o),
    .res_valid_o               (res_valid_o),
    .res_data_o                (res_data_o),
    .res_ready_i               (res_ready_i),
    .timeout_o                 (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [IW-1:0] ref_fin  [K];
  logic [IW-1:0] ref_kern [K];
  logic [OW-1:0] ref_bias = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Window result straight from the definition: bias + sum(fin*kernel).
  function automatic logic [OW-1:0] model_result();
    int s;
    s = int'(ref_bias);
    for (int k = 0; k < K; k++) s += $signed(ref_fin[k]) * $signed(ref_kern[k]);
`ifdef MAC_DRV_RELU_EN
    if (s < 0) s = 0;
`endif
    return OW'(s);
  endfunction

  task automatic write_entry(input logic [AW-1:0] a, input logic [IW-1:0] f, input logic [IW-1:0] kw);
    cfg_wr_en_i = 1'b1; cfg_wr_addr_i = a; cfg_fin_i = f; cfg_kernel_i = kw;
    @(posedge clk_i); #1;
    cfg_wr_en_i = 1'b0;
    if (int'(a) < K) begin
      ref_fin[a]  = f;
      ref_kern[a] = kw;
    end
  endtask

  task automatic write_bias(input logic [OW-1:0] v);
    cfg_bias_wr_en_i = 1'b1; cfg_bias_i = v;
    @(posedge clk_i); #1;
    cfg_bias_wr_en_i = 1'b0;
    ref_bias = v;
  endtask

  function automatic logic [OW-1:0] rand_bias();
    return OW'($urandom_range(0, 2000)) - OW'(1000);
  endfunction

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_valid"},    32'(mac_fin_and_kernel_valid_o), 0);
    check({pfx, "_busy"},     32'(busy_o), 0);
    check({pfx, "_ready"},    32'(mac_ready_o), 0);
    check({pfx, "_resvalid"}, 32'(res_valid_o), 0);
    check({pfx, "_resdata"},  res_data_o, 0);
    check({pfx, "_data"},     {16'd0, mac_fin_data_o, mac_kernel_data_o}, 0);
    check({pfx, "_bias"},     mac_kernel_bias_o, 0);
    check({pfx, "_timeout"},  32'(timeout_o), 0);
  endtask

  // One start-to-IDLE window. The inline MAC stub accumulates what is streamed
  // and answers 3 cycles after valid falls, giving 14-cycle start-to-result.
  task automatic run_window(input bit silent, input int hold, input bit wr_in_stream,
                            input bit wr_with_start);
    int nval, fall_cyc, hleft, phase, p;
    bit fell, done, exp_to;
    logic [OW-1:0] acc, exp_res;
    if (wr_with_start) begin
      cfg_wr_en_i = 1'b1; cfg_wr_addr_i = '0;
      cfg_fin_i = IW'($urandom); cfg_kernel_i = IW'($urandom);
      cfg_bias_wr_en_i = 1'b1; cfg_bias_i = rand_bias();
      ref_fin[0] = cfg_fin_i; ref_kern[0] = cfg_kernel_i; ref_bias = cfg_bias_i;
    end
    exp_res = model_result();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; cfg_wr_en_i = 1'b0; cfg_bias_wr_en_i = 1'b0;
    check("pre_valid", 32'(mac_fin_and_kernel_valid_o), 1);
    check("pre_data", {16'd0, mac_fin_data_o, mac_kernel_data_o}, 0);
    check("busy_start", 32'(busy_o), 1);
    check("bias_out", mac_kernel_bias_o, ref_bias);
    nval = 1; acc = mac_kernel_bias_o; fell = 1'b0; done = 1'b0;
    phase = 0; fall_cyc = 0; hleft = 0;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(posedge clk_i); #1;
      if (fell) begin
        check("valid_after_fall", 32'(mac_fin_and_kernel_valid_o), 0);
      end else if (mac_fin_and_kernel_valid_o) begin
        if (nval <= K) begin
          check("stream_fin", 32'(mac_fin_data_o), 32'(ref_fin[nval-1]));
          check("stream_kern", 32'(mac_kernel_data_o), 32'(ref_kern[nval-1]));
          p = $signed(mac_fin_data_o) * $signed(mac_kernel_data_o);
          acc = acc + OW'(p);
        end
        nval++;
      end else begin
        fell = 1'b1; fall_cyc = cyc;
        check("stream_len", nval, K + 1);
        check("mac_ready_wait", 32'(mac_ready_o), 1);
        check("bias_hold", mac_kernel_bias_o, ref_bias);
      end
      exp_to = silent && fell && (cyc == fall_cyc + TMO);
      check("timeout", 32'(timeout_o), 32'(exp_to));

      if (wr_in_stream && cyc == 5) begin
        cfg_wr_en_i = 1'b1; cfg_wr_addr_i = AW'(4);
        cfg_fin_i = ~ref_fin[4]; cfg_kernel_i = ~ref_kern[4];
        cfg_bias_wr_en_i = 1'b1; cfg_bias_i = ~ref_bias;
      end
      if (cyc == 6) begin
        cfg_wr_en_i = 1'b0; cfg_bias_wr_en_i = 1'b0;
      end

      if (silent) begin
        check("no_result", 32'(res_valid_o), 0);
        if (fell && cyc == fall_cyc + TMO) check("busy_timeout", 32'(busy_o), 0);
        if (fell && cyc == fall_cyc + TMO + 2) done = 1'b1;
      end else begin
        case (phase)
          0: begin
            if (res_valid_o) begin
              check("latency", cyc, 14);
              check("res_data", res_data_o, exp_res);
              check("busy_out", 32'(busy_o), 1);
              check("mac_ready_out", 32'(mac_ready_o), 0);
              mac_data_i = acc ^ 32'h5a5a_5a5a;
              if (hold == 0) begin
                res_ready_i = 1'b1; phase = 2;
              end else begin
                hleft = hold; start_i = 1'b1; phase = 1;
              end
            end else if (fell && cyc == fall_cyc + 3) begin
              mac_valid_i = 1'b1; mac_data_i = acc;
            end
          end
          1: begin
            mac_valid_i = 1'b0;
            check("hold_valid", 32'(res_valid_o), 1);
            check("hold_data", res_data_o, exp_res);
            check("hold_busy", 32'(busy_o), 1);
            hleft--;
            if (hleft == 0) begin
              start_i = 1'b0; res_ready_i = 1'b1; phase = 2;
            end else begin
              start_i = ~start_i;
            end
          end
          2: begin
            mac_valid_i = 1'b0; res_ready_i = 1'b0; start_i = 1'b0;
            check("release_valid", 32'(res_valid_o), 0);
            check("release_busy", 32'(busy_o), 0);
            phase = 3;
          end
          default: begin
            check("idle_resvalid", 32'(res_valid_o), 0);
            check("idle_busy", 32'(busy_o), 0);
            done = 1'b1;
          end
        endcase
      end
    end
    check("window_done", 32'(done), 1);
    mac_valid_i = 1'b0; res_ready_i = 1'b0; start_i = 1'b0;
    cfg_wr_en_i = 1'b0; cfg_bias_wr_en_i = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < K; k++) begin
      ref_fin[k] = '0; ref_kern[k] = '0;
    end
    repeat (3) @(posedge clk_i);
    #1;
    check_idle_outputs("reset");
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    for (int k = 0; k < K; k++) write_entry(AW'(k), IW'(k + 1), IW'(1));
    write_bias(OW'(10));
    run_window(1'b0, 0, 1'b0, 1'b0);

    for (int k = 0; k < K; k++) write_entry(AW'(k), 8'hFE, IW'(3));
    write_bias('0);
    run_window(1'b0, 5, 1'b0, 1'b0);

    run_window(1'b1, 0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      if (r != 2) begin
        for (int k = 0; k < K; k++) write_entry(AW'(k), IW'($urandom), IW'($urandom));
        write_bias(rand_bias());
      end else begin
        write_entry(AW'(12), IW'($urandom), IW'($urandom));
      end
      run_window(1'b0, int'($urandom_range(0, 3)), r == 1, r == 3);
    end

    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    check_idle_outputs("midrst");
    for (int k = 0; k < K; k++) begin
      ref_fin[k] = '0; ref_kern[k] = '0;
    end
    ref_bias = '0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    for (int k = 0; k < 4; k++) write_entry(AW'(k), IW'($urandom), IW'($urandom));
    write_bias(rand_bias());
    run_window(1'b0, 1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
